game_state_ctrl_param: RTL
==========================

// Module: game_state_ctrl_param
// PURPOSE
//  Parametrised top-level Tetris Battle state FSM with a single clock domain and internal 1 Hz tick prescaler.
//  Adds match timeout, pre-game countdown state, early game-over (local top-out or peer over), pb edge detection.
//  Drives stat_out to display/game-logic blocks and the link to the peer board; time_left/cnt_left feed the LCD.
// PARAMETERS
//  TICK_DIV        100_000_000  clk_100 cycles per game-second tick (>=2)
//  GAME_SECONDS    80           game duration in seconds (1..2^TIME_W-1)
//  CNTDOWN_SECONDS 3            pre-game countdown in seconds; 0 skips GAME_CNTDOWN
//  MATCH_TIMEOUT   30           seconds in MATCH_ING before auto-cancel (>=1)
//  TIME_W          7            width of time_left / internal match timer
//  CNT_W           3            width of cnt_left
// PORTS
//  clk_100     in   1       system clock; sole clock
//  rst_n       in   1       synchronous, active-low reset
//  pb_ctl      in   1       debounced control button level
//  game_lost   in   1       local top-out, level, sampled in GAME_ING only
//  peer_valid  in   1       peer_stat is valid this cycle
//  peer_stat   in   3       peer board state code (same encoding as stat_out)
//  stat_out    out  3       current state code
//  time_left   out  TIME_W  game seconds remaining
//  cnt_left    out  CNT_W   countdown seconds remaining
//  tick_1hz    out  1       one-cycle pulse per game-second
//  stat_change out  1       one-cycle pulse in the first cycle stat_out holds a new value
// BEHAVIOUR
//  Codes: NORMAL=0 MATCH_ING=1 MATCH_CANCEL=2 MATCH_SUCCESS=3 GAME_INITIAL=4 GAME_CNTDOWN=5 GAME_ING=6 GAME_OVER=7.
//  Reset (rst_n=0 at edge): stat_out=NORMAL, time_left=GAME_SECONDS, cnt_left=CNTDOWN_SECONDS, tick_1hz=0,
//   stat_change=0, prescaler=0, match timer=MATCH_TIMEOUT, pb_d=1 (button held through reset is no press).
//  Reset mid-game aborts immediately to the reset values; no partial state retained.
//  pb_rise = pb_ctl & ~pb_d; pb_d registered each cycle. All transitions use pb_rise, never level.
//  Latency: inputs sampled at edge n, stat_out/stat_change valid after edge n; one transition per cycle.
//  Prescaler: counts 0..TICK_DIV-1, tick_1hz=1 when count==TICK_DIV-1; clears to 0 on every state change.
//  Transitions (first matching row wins):
//   NORMAL:        pb_rise -> MATCH_ING (match timer loads MATCH_TIMEOUT)
//   MATCH_ING:     peer_valid & peer_stat in {MATCH_ING,MATCH_SUCCESS} -> MATCH_SUCCESS;
//                  pb_rise -> MATCH_CANCEL; tick & match timer==1 -> MATCH_CANCEL; tick -> timer-1
//   MATCH_CANCEL:  -> NORMAL (1 cycle)
//   MATCH_SUCCESS: -> GAME_INITIAL (1 cycle)
//   GAME_INITIAL:  load time_left=GAME_SECONDS, cnt_left=CNTDOWN_SECONDS;
//                  -> GAME_CNTDOWN, or -> GAME_ING if CNTDOWN_SECONDS==0
//   GAME_CNTDOWN:  tick & cnt_left==1 -> GAME_ING with cnt_left=0; tick -> cnt_left-1
//   GAME_ING:      game_lost -> GAME_OVER; peer_valid & peer_stat==GAME_OVER -> GAME_OVER;
//                  tick & time_left==1 -> GAME_OVER with time_left=0; tick -> time_left-1
//   GAME_OVER:     time_left frozen; pb_rise -> NORMAL (time_left, cnt_left reload)
//  Simultaneous match + pb_rise in MATCH_ING: match wins. game_lost + final tick: GAME_OVER, time_left=0.
//  Counters never wrap: no decrement at 0; time_left/cnt_left change only in states listed above.
//  Unused codes unreachable; any illegal stat_out recovers to NORMAL next cycle.
// STRUCTURE
//  Shared package game_state_pkg: 3-bit state code constants (NORMAL..GAME_OVER), STAT_W=3.
//  Sub-module tick_prescaler (TICK_DIV; inputs clk_100, rst_n, clr; output tick) instantiated once.
//  FSM, pb edge detect, match timer, time_left/cnt_left counters in this module.
// TESTING (TICK_DIV=4, GAME_SECONDS=5, CNTDOWN_SECONDS=2, MATCH_TIMEOUT=3)
//  Reset with pb_ctl=1, release rst_n, hold pb -> stat_out stays 0; drop+raise pb -> stat_out=1, stat_change pulse.
//  MATCH_ING, peer_valid=1 peer_stat=1 same cycle as pb_rise -> 3,4,5 on consecutive edges; cnt_left 2->1->0 every 4 cycles, then 6.
//  MATCH_ING, no peer, no pb -> after 3 ticks (12 cycles) stat_out=2, next cycle 0.
//  GAME_ING full run -> time_left 5,4,3,2,1,0 one per 4 cycles; stat_out=7 with time_left=0; pb_rise -> 0, time_left=5.
//  GAME_ING, time_left=3, game_lost=1 -> stat_out=7 next edge, time_left frozen at 3; peer_stat=7 gives same result.
//  rst_n=0 during GAME_CNTDOWN -> next edge all outputs at reset values, tick_1hz=0.

Source files
------------

// File: rtl/game_state_pkg.sv
// Shared state codes for the Tetris Battle board controller and its peer link.
// The same 3-bit encoding is used on stat_out and on the incoming peer_stat.
package game_state_pkg;

  localparam int STAT_W = 3;

  typedef enum logic [STAT_W-1:0] {
    NORMAL        = 3'd0,
    MATCH_ING     = 3'd1,
    MATCH_CANCEL  = 3'd2,
    MATCH_SUCCESS = 3'd3,
    GAME_INITIAL  = 3'd4,
    GAME_CNTDOWN  = 3'd5,
    GAME_ING      = 3'd6,
    GAME_OVER     = 3'd7
  } stat_e;

  // A peer that is searching or has already locked a match completes our match.
  function automatic logic peer_ready(input logic [STAT_W-1:0] code);
    return (code == MATCH_ING) || (code == MATCH_SUCCESS);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_100 down to a one-cycle game-second pulse; clr restarts the second
// so every state begins with a full second before its first tick.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_100) begin
    if (!rst_n || clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/game_state_ctrl_param.sv
// Top-level Tetris Battle state machine: matchmaking, countdown, timed game and
// game-over handling, with second ticks derived from an internal prescaler.
module game_state_ctrl_param
  import game_state_pkg::*;
#(
  parameter int TICK_DIV        = 100_000_000,
  parameter int GAME_SECONDS    = 80,
  parameter int CNTDOWN_SECONDS = 3,
  parameter int MATCH_TIMEOUT   = 30,
  parameter int TIME_W          = 7,
  parameter int CNT_W           = 3
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              pb_ctl,
  input  logic              game_lost,
  input  logic              peer_valid,
  input  logic [STAT_W-1:0] peer_stat,
  output logic [STAT_W-1:0] stat_out,
  output logic [TIME_W-1:0] time_left,
  output logic [CNT_W-1:0]  cnt_left,
  output logic              tick_1hz,
  output logic              stat_change
);

  localparam logic [TIME_W-1:0] GAME_INIT  = TIME_W'(GAME_SECONDS);
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(CNTDOWN_SECONDS);
  localparam logic [TIME_W-1:0] MATCH_INIT = TIME_W'(MATCH_TIMEOUT);
  localparam logic [TIME_W-1:0] TIME_ONE   = TIME_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  stat_e             state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] mtmr_q, mtmr_d;
  logic              pb_d;
  logic              pb_rise;
  logic              tick;
  logic              state_chg;
  logic              peer_match;
  logic              peer_over;

  assign pb_rise    = pb_ctl & ~pb_d;
  assign peer_match = peer_valid & peer_ready(peer_stat);
  assign peer_over  = peer_valid & (peer_stat == GAME_OVER);
  assign state_chg  = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (state_chg),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    mtmr_d  = mtmr_q;
    case (state_q)
      NORMAL: begin
        if (pb_rise) begin
          state_d = MATCH_ING;
          mtmr_d  = MATCH_INIT;
        end
      end
      MATCH_ING: begin
        // A match arriving with a cancel press still wins.
        if (peer_match) begin
          state_d = MATCH_SUCCESS;
        end else if (pb_rise) begin
          state_d = MATCH_CANCEL;
        end else if (tick) begin
          if (mtmr_q == TIME_ONE) begin
            state_d = MATCH_CANCEL;
          end else if (mtmr_q != '0) begin
            mtmr_d = mtmr_q - TIME_ONE;
          end
        end
      end
      MATCH_CANCEL: state_d = NORMAL;
      MATCH_SUCCESS: state_d = GAME_INITIAL;
      GAME_INITIAL: begin
        time_d  = GAME_INIT;
        cnt_d   = CNT_INIT;
        state_d = (CNTDOWN_SECONDS == 0) ? GAME_ING : GAME_CNTDOWN;
      end
      GAME_CNTDOWN: begin
        if (tick) begin
          if ((cnt_q == CNT_ONE) || (cnt_q == '0)) begin
            state_d = GAME_ING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      GAME_ING: begin
        // The last second expiring takes priority so time_left always reads 0.
        if (tick && (time_q == TIME_ONE)) begin
          state_d = GAME_OVER;
          time_d  = '0;
        end else if (game_lost || peer_over) begin
          state_d = GAME_OVER;
        end else if (tick && (time_q != '0)) begin
          time_d = time_q - TIME_ONE;
        end
      end
      GAME_OVER: begin
        if (pb_rise) begin
          state_d = NORMAL;
          time_d  = GAME_INIT;
          cnt_d   = CNT_INIT;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      time_q      <= GAME_INIT;
      cnt_q       <= CNT_INIT;
      mtmr_q      <= MATCH_INIT;
      pb_d        <= 1'b1;
      stat_change <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      cnt_q       <= cnt_d;
      mtmr_q      <= mtmr_d;
      pb_d        <= pb_ctl;
      stat_change <= state_chg;
    end
  end

  assign stat_out  = state_q;
  assign time_left = time_q;
  assign cnt_left  = cnt_q;
  assign tick_1hz  = tick;

endmodule
